// File: rtl/vec_pe_dispatch.sv
// Vector-op sequencer: walks a vector register word by word through a single PE
// and reports exactly one completion per accepted request.
module vec_pe_dispatch #(
  parameter int IDX_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_instr,
  input  logic [4:0]       req_vs1,
  input  logic [4:0]       req_vs2,
  input  logic [4:0]       req_vs3,
  input  logic [4:0]       req_vd,
  input  logic [31:0]      req_vl,
  input  logic [31:0]      req_sew,
  input  logic [3:0]       req_vap,
  output logic             busy,
  output logic             cmpl,
  output logic             cmpl_err,
  output logic             rf_ren,
  output logic [IDX_W-1:0] rf_idx,
  output logic [4:0]       rf_rs1,
  output logic [4:0]       rf_rs2,
  output logic [4:0]       rf_rs3,
  input  logic [31:0]      rf_rdata1,
  input  logic [31:0]      rf_rdata2,
  input  logic [31:0]      rf_rdata3,
  output logic             rf_we,
  output logic [4:0]       rf_wreg,
  output logic [IDX_W-1:0] rf_widx,
  output logic [31:0]      rf_wdata,
  output logic [7:0]       pe_instruction,
  output logic             pe_start,
  output logic [31:0]      pe_opA,
  output logic [31:0]      pe_opB,
  output logic [31:0]      pe_opC,
  output logic [31:0]      pe_SEW,
  output logic [3:0]       pe_vap,
  input  logic             pe_done,
  input  logic [31:0]      pe_peout,
  output logic [2:0]       o_dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t r_state, w_next;

  logic [7:0]       r_instr;
  logic [4:0]       r_vs1, r_vs2, r_vs3, r_vd;
  logic [31:0]      r_sew;
  logic [3:0]       r_vap;
  logic [IDX_W:0]   r_n;
  logic             r_err;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_opa, r_opb, r_opc, r_wdata;

  logic [32:0]      w_vl33, w_n;
  logic             w_sew_ok, w_err, w_zero, w_accept, w_last, w_timeout;
  logic [CNT_W-1:0] w_cnt_inc;

  // Word count is formed in 33 bits so vl near 2^32 cannot wrap into a legal N.
  assign w_vl33 = {1'b0, req_vl};

  always_comb begin
    w_n      = '0;
    w_sew_ok = 1'b1;
    case (req_sew)
      32'd32:  w_n = w_vl33;
      32'd16:  w_n = (w_vl33 + 33'd1) >> 1;
      32'd8:   w_n = (w_vl33 + 33'd3) >> 2;
      default: w_sew_ok = 1'b0;
    endcase
  end

  // Request handshake: a request transfers on a clock edge where req_valid and
  // req_ready are both high; req_ready is high only in IDLE.
  assign w_err     = !w_sew_ok || (w_n > (33'd1 << IDX_W));
  assign w_zero    = (w_n == 33'd0);
  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_last    = (({1'b0, r_idx} + (IDX_W+1)'(1)) == r_n);
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_timeout = (w_cnt_inc == CNT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = (w_err || w_zero) ? S_DONE : S_READ;
      S_READ:  w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (pe_done)        w_next = S_WRITE;
        else if (w_timeout) w_next = S_DONE;
      end
      S_WRITE: w_next = w_last ? S_DONE : S_READ;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr <= '0;
      r_vs1   <= '0;
      r_vs2   <= '0;
      r_vs3   <= '0;
      r_vd    <= '0;
      r_sew   <= '0;
      r_vap   <= '0;
      r_n     <= '0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_opc   <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_instr <= req_instr;
          r_vs1   <= req_vs1;
          r_vs2   <= req_vs2;
          r_vs3   <= req_vs3;
          r_vd    <= req_vd;
          r_sew   <= req_sew;
          r_vap   <= req_vap;
          r_n     <= w_n[IDX_W:0];
          r_err   <= w_err;
          r_idx   <= '0;
        end
        S_ISSUE: begin
          r_opa <= rf_rdata1;
          r_opb <= rf_rdata2;
          r_opc <= rf_rdata3;
          r_cnt <= '0;
        end
        S_WAIT: begin
          if (pe_done) begin
            r_wdata <= pe_peout;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_timeout) r_err <= 1'b1;
          end
        end
        S_WRITE: if (!w_last) r_idx <= r_idx + IDX_W'(1);
        default: ;
      endcase
    end
  end

  assign req_ready      = (r_state == S_IDLE);
  assign busy           = (r_state != S_IDLE);
  assign rf_ren         = (r_state == S_READ);
  assign pe_start       = (r_state == S_ISSUE);
  assign rf_we          = (r_state == S_WRITE);
  assign cmpl           = (r_state == S_DONE);
  assign cmpl_err       = (r_state == S_DONE) && r_err;
  assign rf_idx         = r_idx;
  assign rf_widx        = r_idx;
  assign rf_rs1         = r_vs1;
  assign rf_rs2         = r_vs2;
  assign rf_rs3         = r_vs3;
  assign rf_wreg        = r_vd;
  assign rf_wdata       = r_wdata;
  assign pe_instruction = r_instr;
  assign pe_SEW         = r_sew;
  assign pe_vap         = r_vap;
  // Operands go straight through while start is high, then stay held from the registers.
  assign pe_opA         = (r_state == S_ISSUE) ? rf_rdata1 : r_opa;
  assign pe_opB         = (r_state == S_ISSUE) ? rf_rdata2 : r_opb;
  assign pe_opC         = (r_state == S_ISSUE) ? rf_rdata3 : r_opc;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_vec_pe_dispatch.sv
// Directed bench for vec_pe_dispatch: RF and PE models, write scoreboard, timing checks.
module tb_vec_pe_dispatch;
  localparam int IDX_W = 8;
  localparam int W     = 5 + IDX_W + 32;
  localparam logic [31:0] HOLD_VAL = 32'h5A5A_0001;

  logic clk = 1'b0;
  logic reset;
  logic req_valid, req_valid_to;
  logic [7:0]  req_instr;
  logic [4:0]  req_vs1, req_vs2, req_vs3, req_vd;
  logic [31:0] req_vl, req_sew;
  logic [3:0]  req_vap;

  logic busy, req_ready, cmpl, cmpl_err, rf_ren, rf_we, pe_start, pe_done;
  logic [IDX_W-1:0] rf_idx, rf_widx;
  logic [4:0]  rf_rs1, rf_rs2, rf_rs3, rf_wreg;
  logic [31:0] rf_rdata1, rf_rdata2, rf_rdata3, rf_wdata;
  logic [7:0]  pe_instruction;
  logic [31:0] pe_opA, pe_opB, pe_opC, pe_SEW, pe_peout;
  logic [3:0]  pe_vap;
  logic [2:0]  dbg_state;

  logic to_busy, to_req_ready, to_cmpl, to_cmpl_err, to_rf_ren, to_rf_we, to_pe_start;
  logic [IDX_W-1:0] to_rf_idx, to_rf_widx;
  logic [4:0]  to_rf_rs1, to_rf_rs2, to_rf_rs3, to_rf_wreg;
  logic [31:0] to_rf_wdata, to_pe_opA, to_pe_opB, to_pe_opC, to_pe_SEW;
  logic [7:0]  to_pe_instruction;
  logic [3:0]  to_pe_vap;
  logic [2:0]  to_dbg_state;

  int n_chk = 0, n_fail = 0;
  int n_ren = 0, n_start = 0, n_we = 0, n_cmpl = 0, n_overlap = 0;
  int n_to_start = 0, n_to_we = 0;
  logic [31:0] cur_sew;
  logic [W-1:0] exp_q[$];

  int pe_mode, pe_lat, pe_cnt, pe_l;
  bit pe_rand;
  logic [31:0] pe_res;

  logic [31:0] mem [0:31][0:255];
  bit          wv  [0:31][0:255];

  always #5 clk = ~clk;

  vec_pe_dispatch #(.IDX_W(IDX_W), .TIMEOUT(255)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_instr(req_instr), .req_vs1(req_vs1), .req_vs2(req_vs2), .req_vs3(req_vs3),
    .req_vd(req_vd), .req_vl(req_vl), .req_sew(req_sew), .req_vap(req_vap),
    .busy(busy), .cmpl(cmpl), .cmpl_err(cmpl_err),
    .rf_ren(rf_ren), .rf_idx(rf_idx), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rs3(rf_rs3),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .rf_rdata3(rf_rdata3),
    .rf_we(rf_we), .rf_wreg(rf_wreg), .rf_widx(rf_widx), .rf_wdata(rf_wdata),
    .pe_instruction(pe_instruction), .pe_start(pe_start), .pe_opA(pe_opA),
    .pe_opB(pe_opB), .pe_opC(pe_opC), .pe_SEW(pe_SEW), .pe_vap(pe_vap),
    .pe_done(pe_done), .pe_peout(pe_peout), .o_dbg_state(dbg_state)
  );

  // Second instance with a short timeout and a PE that never answers.
  vec_pe_dispatch #(.IDX_W(IDX_W), .TIMEOUT(4)) u_dut_to (
    .clk(clk), .reset(reset), .req_valid(req_valid_to), .req_ready(to_req_ready),
    .req_instr(req_instr), .req_vs1(req_vs1), .req_vs2(req_vs2), .req_vs3(req_vs3),
    .req_vd(req_vd), .req_vl(req_vl), .req_sew(req_sew), .req_vap(req_vap),
    .busy(to_busy), .cmpl(to_cmpl), .cmpl_err(to_cmpl_err),
    .rf_ren(to_rf_ren), .rf_idx(to_rf_idx), .rf_rs1(to_rf_rs1), .rf_rs2(to_rf_rs2),
    .rf_rs3(to_rf_rs3), .rf_rdata1(32'h0), .rf_rdata2(32'h0), .rf_rdata3(32'h0),
    .rf_we(to_rf_we), .rf_wreg(to_rf_wreg), .rf_widx(to_rf_widx), .rf_wdata(to_rf_wdata),
    .pe_instruction(to_pe_instruction), .pe_start(to_pe_start), .pe_opA(to_pe_opA),
    .pe_opB(to_pe_opB), .pe_opC(to_pe_opC), .pe_SEW(to_pe_SEW), .pe_vap(to_pe_vap),
    .pe_done(1'b0), .pe_peout(32'h0), .o_dbg_state(to_dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pe_fn(input logic [7:0] op, input logic [31:0] a, b, c);
    case (op)
      8'h00:   return a + b;
      8'h01:   return a * b;
      default: return a * b + c;
    endcase
  endfunction

  function automatic logic [31:0] rf_init(input int r, input int i);
    case (r)
      1:       return 32'(i + 1);
      2:       return 32'((i + 1) * 10);
      3:       return 32'(i + 100);
      default: return 32'(r * 1000 + i);
    endcase
  endfunction

  function automatic logic [31:0] rf_word(input int r, input int i);
    return wv[r][i] ? mem[r][i] : rf_init(r, i);
  endfunction

  // RF model: one-cycle read latency, write on rf_we.
  always @(posedge clk) begin
    if (rf_ren) begin
      rf_rdata1 <= rf_word(int'(rf_rs1), int'(rf_idx));
      rf_rdata2 <= rf_word(int'(rf_rs2), int'(rf_idx));
      rf_rdata3 <= rf_word(int'(rf_rs3), int'(rf_idx));
    end
    if (rf_we) begin
      mem[rf_wreg][rf_widx] <= rf_wdata;
      wv[rf_wreg][rf_widx]  <= 1'b1;
    end
  end

  // PE model: mode 0 answers after pe_lat (or random 1..10) cycles, 1 never, 2 holds done.
  always @(posedge clk) begin
    if (reset || pe_mode == 1) begin
      pe_done  <= 1'b0;
      pe_cnt   <= 0;
      pe_peout <= 32'h0;
    end else if (pe_mode == 2) begin
      pe_done  <= 1'b1;
      pe_peout <= HOLD_VAL;
    end else begin
      pe_done <= 1'b0;
      if (pe_start) begin
        pe_l = pe_rand ? int'($urandom_range(10, 1)) : pe_lat;
        if (pe_l == 1) begin
          pe_done  <= 1'b1;
          pe_peout <= pe_fn(pe_instruction, pe_opA, pe_opB, pe_opC);
        end else begin
          pe_cnt <= pe_l - 1;
          pe_res <= pe_fn(pe_instruction, pe_opA, pe_opB, pe_opC);
        end
      end else if (pe_cnt != 0) begin
        pe_cnt <= pe_cnt - 1;
        if (pe_cnt == 1) begin
          pe_done  <= 1'b1;
          pe_peout <= pe_res;
        end
      end
    end
  end

  // Monitor and write scoreboard.
  always @(posedge clk) begin
    logic [W-1:0] e;
    if (rf_ren) n_ren++;
    if (cmpl) n_cmpl++;
    if (pe_start && rf_we) n_overlap++;
    if (to_pe_start) n_to_start++;
    if (to_rf_we) n_to_we++;
    if (pe_start) begin
      n_start++;
      check("pe_sew", pe_SEW, cur_sew);
    end
    if (rf_we) begin
      n_we++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : {W{1'bx}};
      check("wr", {rf_wreg, rf_widx, rf_wdata}, e);
    end
  end

  task automatic push_exp(input logic [4:0] d, input int i, input logic [31:0] v);
    exp_q.push_back({d, IDX_W'(i), v});
  endtask

  task automatic send_req(input logic [7:0] ins, input logic [4:0] s1, s2, s3, d,
                          input logic [31:0] vl, sew);
    @(negedge clk);
    check("ready_idle", req_ready, 1);
    req_instr = ins; req_vs1 = s1; req_vs2 = s2; req_vs3 = s3; req_vd = d;
    req_vl = vl; req_sew = sew; req_vap = 4'h5; cur_sew = sew;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_cmpl(input int bound, output int cyc, output logic err);
    cyc = 0;
    err = 1'bx;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check("busy_c1", busy, 1);
        check("ready_c1", req_ready, 0);
      end
      if (cmpl) begin
        err = cmpl_err;
        break;
      end
      if (cyc >= bound) begin
        check("cmpl_seen", cmpl, 1);
        cyc = -1;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] ins, input logic [4:0] s1, s2, s3, d,
                        input logic [31:0] vl, sew, input int n_words, input bit golden,
                        input int exp_cyc, input logic exp_err, input int bound);
    int ren0, st0, we0, cm0, cyc;
    logic err;
    ren0 = n_ren; st0 = n_start; we0 = n_we; cm0 = n_cmpl;
    if (golden)
      for (int i = 0; i < n_words; i++)
        push_exp(d, i, pe_fn(ins, rf_word(int'(s1), i), rf_word(int'(s2), i), rf_word(int'(s3), i)));
    send_req(ins, s1, s2, s3, d, vl, sew);
    wait_cmpl(bound, cyc, err);
    if (exp_cyc > 0) check({tag, "_cyc"}, cyc, exp_cyc);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_nren"}, n_ren - ren0, n_words);
    check({tag, "_nstart"}, n_start - st0, n_words);
    check({tag, "_nwe"}, n_we - we0, n_words);
    @(negedge clk);
    check({tag, "_ready_after"}, req_ready, 1);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_ncmpl"}, n_cmpl - cm0, 1);
    check({tag, "_q_empty"}, exp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, req_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cmpl"}, {cmpl, cmpl_err}, 0);
    check({tag, "_strobes"}, {rf_ren, rf_we, pe_start}, 0);
    check({tag, "_addr"}, {rf_idx, rf_widx, rf_rs1, rf_rs2, rf_rs3, rf_wreg}, 0);
    check({tag, "_wdata"}, rf_wdata, 0);
    check({tag, "_ops"}, {pe_opA, pe_opB}, 0);
    check({tag, "_opc_sew"}, {pe_opC, pe_SEW}, 0);
    check({tag, "_instr_vap"}, {pe_instruction, pe_vap}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, st0, we0, cm0, to_st0, to_we0;
    bit found;
    reset = 1'b1; req_valid = 1'b0; req_valid_to = 1'b0;
    req_instr = '0; req_vs1 = '0; req_vs2 = '0; req_vs3 = '0; req_vd = '0;
    req_vl = '0; req_sew = '0; req_vap = '0; cur_sew = '0;
    pe_mode = 0; pe_lat = 1; pe_rand = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("rst");

    run_op("vadd32", 8'h00, 5'd1, 5'd2, 5'd3, 5'd4, 32'd3, 32'd32, 3, 1'b1, 13, 1'b0, 40);
    run_op("sew8",   8'h01, 5'd1, 5'd2, 5'd3, 5'd6, 32'd5, 32'd8, 2, 1'b1, 9, 1'b0, 40);
    run_op("sew16",  8'h00, 5'd1, 5'd2, 5'd3, 5'd7, 32'd5, 32'd16, 3, 1'b1, 13, 1'b0, 40);
    run_op("vl0",    8'h00, 5'd1, 5'd2, 5'd3, 5'd8, 32'd0, 32'd32, 0, 1'b1, 1, 1'b0, 10);
    run_op("sew12",  8'h00, 5'd1, 5'd2, 5'd3, 5'd8, 32'd4, 32'd12, 0, 1'b1, 1, 1'b1, 10);
    run_op("n257",   8'h00, 5'd1, 5'd2, 5'd3, 5'd8, 32'd257, 32'd32, 0, 1'b1, 1, 1'b1, 10);
    run_op("vlmax8", 8'h00, 5'd1, 5'd2, 5'd3, 5'd8, 32'hFFFF_FFFF, 32'd8, 0, 1'b1, 1, 1'b1, 10);
    run_op("n256",   8'h00, 5'd1, 5'd2, 5'd3, 5'd13, 32'd256, 32'd32, 256, 1'b1, 1025, 1'b0, 1100);

    // In-place: vd equals vs1, PE latency 2 gives 5 cycles per word.
    pe_lat = 2;
    run_op("inplace", 8'h00, 5'd10, 5'd2, 5'd3, 5'd10, 32'd4, 32'd32, 4, 1'b1, 21, 1'b0, 60);

    pe_lat = 1;
    pe_rand = 1'b1;
    run_op("randlat", 8'h02, 5'd1, 5'd2, 5'd3, 5'd9, 32'd6, 32'd32, 6, 1'b1, 0, 1'b0, 120);
    pe_rand = 1'b0;

    pe_mode = 2;
    push_exp(5'd14, 0, HOLD_VAL);
    push_exp(5'd14, 1, HOLD_VAL);
    run_op("hold", 8'h00, 5'd1, 5'd2, 5'd3, 5'd14, 32'd2, 32'd32, 2, 1'b0, 9, 1'b0, 40);
    pe_mode = 0;

    // Timeout on the second instance: READ, ISSUE, 4 WAIT cycles, then DONE.
    to_st0 = n_to_start; to_we0 = n_to_we;
    @(negedge clk);
    req_instr = 8'h00; req_vs1 = 5'd1; req_vs2 = 5'd2; req_vs3 = 5'd3; req_vd = 5'd15;
    req_vl = 32'd3; req_sew = 32'd32; req_valid_to = 1'b1;
    @(posedge clk);
    #1 req_valid_to = 1'b0;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (to_cmpl) break;
      if (cyc >= 40) begin
        check("to_cmpl_seen", to_cmpl, 1);
        break;
      end
    end
    check("to_cyc", cyc, 7);
    check("to_err", to_cmpl_err, 1);
    check("to_nstart", n_to_start - to_st0, 1);
    check("to_nwe", n_to_we - to_we0, 0);
    @(negedge clk);
    check("to_ready_after", to_req_ready, 1);

    // Reset during WAIT of word 1 of 4.
    st0 = n_start; we0 = n_we; cm0 = n_cmpl;
    push_exp(5'd11, 0, pe_fn(8'h00, rf_word(1, 0), rf_word(2, 0), rf_word(3, 0)));
    send_req(8'h00, 5'd1, 5'd2, 5'd3, 5'd11, 32'd4, 32'd32);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dbg_state == 3'd3 && rf_idx == 1) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_reach_wait1", found, 1);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_ncmpl", n_cmpl - cm0, 0);
    check("midrst_nwe", n_we - we0, 1);
    check("midrst_nstart", n_start - st0, 2);
    check("midrst_q_empty", exp_q.size(), 0);

    run_op("after_rst", 8'h00, 5'd1, 5'd2, 5'd3, 5'd12, 32'd2, 32'd32, 2, 1'b1, 9, 1'b0, 40);

    check("start_we_overlap", n_overlap, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_pe_dispatch.md
# vec_pe_dispatch

Sequencer that drives one `vector_processing_element` from the vector coprocessor side. It accepts a vector-arithmetic request, reads 32-bit operand words from the vector register file, and issues each word to the PE with `start`. It waits for `done`, then writes `peout` back to the destination register. It signals completion once per request, so the coprocessor sees a whole vector op as one transaction instead of per-word PE handshakes.

## Interface
- `IDX_W`, 8: word-index width within a vector register (max 2^IDX_W words).
- `TIMEOUT`, 255: max cycles spent waiting for `pe_done` per word before aborting.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1 / `req_ready` out 1: request handshake; accepted on a cycle with both high.
- `req_instr` in 8: PE opcode (`00` vadd, `01` vmul, `02` vdot, `03`–`05` varp forms), passed through unchanged.
- `req_vs1`, `req_vs2`, `req_vs3`, `req_vd` in 5 each: source and destination vector register numbers.
- `req_vl` in 32: vector length in elements.
- `req_sew` in 32: element width, legal values 8, 16 and 32.
- `req_vap` in 4: variable-precision field, passed through.
- `busy` out 1: a request is in flight.
- `cmpl` out 1: one-cycle completion pulse. `cmpl_err` out 1: valid with `cmpl`.
- `rf_ren` out 1, `rf_idx` out IDX_W, `rf_rs1`/`rf_rs2`/`rf_rs3` out 5: three parallel reads at the same word index.
- `rf_rdata1`/`rf_rdata2`/`rf_rdata3` in 32: read data, valid the cycle after `rf_ren`.
- `rf_we` out 1, `rf_wreg` out 5, `rf_widx` out IDX_W, `rf_wdata` out 32: write port.
- `pe_instruction` out 8, `pe_start` out 1, `pe_opA`/`pe_opB`/`pe_opC` out 32, `pe_SEW` out 32, `pe_vap` out 4: PE drive.
- `pe_done` in 1, `pe_peout` in 32: PE result.

## Operation
- Request fields are latched on acceptance and held stable on the `pe_*` outputs for the whole request.
- Word count N is computed as follows. SEW=32: N=vl. SEW=16: N=(vl+1)>>1. SEW=8: N=(vl+3)>>2. N is computed in 33 bits, so there is no overflow.
- Error conditions are an illegal SEW, or N > 2^IDX_W. On either, the block goes straight to DONE with `cmpl_err`=1 and does no RF or PE activity.
- vl=0 goes straight to DONE with `cmpl_err`=0.
- FSM states:
  - IDLE: `req_ready`=1. On accept, go to READ with idx=0, or to DONE for the vl=0 and error cases.
  - READ: `rf_ren`=1, `rf_idx`=idx. Go to ISSUE.
  - ISSUE: latch `rf_rdata1/2/3` into `pe_opA/B/C`, pulse `pe_start` for one cycle, clear the timeout counter. Go to WAIT.
  - WAIT: `pe_done` is sampled only in this state, so any `done` level during ISSUE is ignored.
    - If `pe_done`=1, latch `pe_peout` into `rf_wdata` and go to WRITE.
    - Otherwise increment the counter; if it reaches TIMEOUT, go to DONE with error set and no write.
  - WRITE: `rf_we`=1, `rf_wreg`=vd, `rf_widx`=idx. If idx==N-1, go to DONE. Otherwise idx++ and go to READ.
  - DONE: `cmpl`=1 for one cycle, `cmpl_err` per the latched error. Go to IDLE.
- `busy`=1 in every state except IDLE.
- In-place operation is legal (vd equal to a source register), because each word is read before it is written.
- The PE contract is that `done` deasserts within one cycle after `start`. A stale `done` level is a PE bug, but it still yields exactly one write per word.

## Timing
- Reset values: `req_ready`=1. All other outputs 0: `busy`, `cmpl`, `cmpl_err`, `rf_ren`, `rf_we`, `pe_start`, all addresses and indices, all data and opcode outputs. FSM is in IDLE and idx=0.
- Reset asserted mid-request aborts on the next edge. No further `rf_we` or `pe_start` occurs, and `cmpl` is not pulsed.
- Per word: READ(1) + ISSUE(1) + WAIT(k≥1) + WRITE(1).
  - With a PE whose `done` arrives 1 cycle after `start` (k=1), a word takes 4 cycles.
  - For such a PE, `cmpl` is high 4N+1 cycles after the accept edge.
- `req_ready` is low from the cycle after accept until the cycle after `cmpl`. Back-to-back requests are therefore separated by at least one IDLE cycle.
- `pe_start` and `rf_we` are never high in the same cycle. At most one `pe_start` is issued per word.

## Test plan
- vadd, SEW=32, vl=3, vs1 words {1,2,3}, vs2 {10,20,30}, PE done latency 1 -> three writes to vd idx 0..2 with {11,22,33}, `cmpl` at cycle 13, `cmpl_err`=0.
- SEW=8, vl=5 -> N=2 (2 reads, 2 `pe_start`, 2 writes). SEW=16, vl=5 -> N=3. `pe_SEW` equals `req_sew` throughout.
- vl=0 -> `cmpl` 1 cycle after accept, no `rf_ren` or `rf_we`. SEW=12 -> same timing with `cmpl_err`=1.
- PE model never asserts `done`, TIMEOUT=4 -> single `pe_start`, no `rf_we`, `cmpl`+`cmpl_err` after 4 WAIT cycles, then `req_ready`=1.
- PE holds `done`=1 permanently, vl=2 SEW=32 -> exactly 2 writes and correct indices. PE with random latency 1–10 -> results match a golden model.
- `reset` pulsed during WAIT of word 1 of 4 -> all outputs 0 next cycle, `req_ready`=1, no `cmpl`. A new request then completes normally.
